// File: rtl/serial_mem_bridge.sv
// Byte-serial command bridge: framed rx bytes drive a memory port; each frame returns DATA_BYTES response bytes.
// Optional inter-byte timeout on partial frames is enabled by defining SERIAL_MEM_BRIDGE_TIMEOUT_EN.
module serial_mem_bridge #(
   parameter int DATA_BYTES  = 4,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 12000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rcv,
   input  logic [7:0]              rxdata,
   output logic                    tx_strb,
   output logic [7:0]              txdata,
   input  logic                    ready,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*DATA_BYTES-1:0] mem_wr_d,
   output logic                    mem_wr_req,
   output logic                    mem_rd_req,
   input  logic [8*DATA_BYTES-1:0] mem_rd_d,
   input  logic                    mem_rd_rdy,
   input  logic                    mem_busy,
   output logic [7:0]              err_cnt
);
   localparam int DW = 8*DATA_BYTES;
   localparam logic [2:0] BCNT_LAST = 3'(DATA_BYTES);
   localparam logic [1:0] TCNT_LAST = 2'(DATA_BYTES-1);

   typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_MEM_WAIT, ST_TX} state_t;

   function automatic logic [DW-1:0] fit(input logic [31:0] v);
      return v[DW-1:0];
   endfunction

   state_t            r_state;
   logic [2:0]        r_byte_cnt;
   logic [1:0]        r_tx_cnt;
   logic [7:0]        r_cmd;
   logic [DW-1:0]     r_payload;
   logic [DW-1:0]     r_resp;
   logic [DW-1:0]     r_rd_hold;
   logic [DW-1:0]     r_wr_d;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_count;
   logic [7:0]        r_err_cnt;
   logic [7:0]        r_txdata;
   logic              r_tx_strb;
   logic              r_wr_req;
   logic              r_rd_req;
   logic              r_in_flight;
   logic              r_seen_low;

   logic [DW+7:0]     w_shift;
   logic [ADDR_W-1:0] w_pay_addr;
   logic              w_rcv_drop;
   logic              w_unknown;
   logic              w_timeout;
   logic [1:0]        w_err_add;
   logic [8:0]        w_err_sum;

   assign w_shift = {r_payload, rxdata};

   generate
      if (ADDR_W <= DW) begin : g_addr_trunc
         assign w_pay_addr = r_payload[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign w_pay_addr = {{(ADDR_W-DW){1'b0}}, r_payload};
      end
   endgenerate

`ifdef SERIAL_MEM_BRIDGE_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYC+1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC-1);
   logic [GAP_W-1:0] r_gap_cnt;

   assign w_timeout = (r_state == ST_RX) && !rcv && (r_byte_cnt != 3'd0) && (r_gap_cnt == GAP_LAST);

   // Gap counter only runs while a partial frame sits idle in RX.
   always_ff @(posedge clk) begin
      if (reset || r_state != ST_RX || rcv || r_byte_cnt == 3'd0 || w_timeout) r_gap_cnt <= '0;
      else                                                                      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign w_rcv_drop = rcv && (r_state != ST_RX);
   assign w_unknown  = (r_state == ST_EXEC) && ((r_cmd == 8'h00) || (r_cmd > 8'h09));
   assign w_err_add  = {1'b0, w_rcv_drop} + {1'b0, w_unknown} + {1'b0, w_timeout};
   assign w_err_sum  = {1'b0, r_err_cnt} + {7'b0, w_err_add};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RX;
         r_byte_cnt  <= '0;
         r_tx_cnt    <= '0;
         r_cmd       <= '0;
         r_payload   <= '0;
         r_resp      <= '0;
         r_rd_hold   <= '0;
         r_wr_d      <= '0;
         r_mem_addr  <= '0;
         r_count     <= '0;
         r_err_cnt   <= '0;
         r_txdata    <= '0;
         r_tx_strb   <= 1'b0;
         r_wr_req    <= 1'b0;
         r_rd_req    <= 1'b0;
         r_in_flight <= 1'b0;
         r_seen_low  <= 1'b0;
      end else begin
         r_tx_strb <= 1'b0;
         r_wr_req  <= 1'b0;
         r_rd_req  <= 1'b0;
         r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
         if (mem_rd_rdy) r_rd_hold <= mem_rd_d;

         // A byte stays in flight until ready has dropped and come back.
         if (r_in_flight) begin
            if (!ready)          r_seen_low  <= 1'b1;
            else if (r_seen_low) r_in_flight <= 1'b0;
         end

         case (r_state)
            ST_RX: begin
               if (rcv) begin
                  if (r_byte_cnt == 3'd0) r_cmd     <= rxdata;
                  else                    r_payload <= w_shift[DW-1:0];
                  if (r_byte_cnt == BCNT_LAST) begin
                     r_byte_cnt <= '0;
                     r_state    <= ST_EXEC;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 3'd1;
                  end
               end else if (w_timeout) begin
                  r_byte_cnt <= '0;
               end
            end
            ST_EXEC: begin
               case (r_cmd)
                  8'h01: begin r_mem_addr <= w_pay_addr; r_resp <= r_payload; r_state <= ST_TX; end
                  8'h02: begin r_wr_d <= r_payload; r_resp <= r_payload; r_state <= ST_TX; end
                  8'h03: if (!mem_busy) begin r_wr_req <= 1'b1; r_resp <= fit(32'h3); r_state <= ST_TX; end
                  8'h04: begin r_resp <= r_rd_hold; r_state <= ST_TX; end
                  8'h05: if (!mem_busy) begin r_rd_req <= 1'b1; r_resp <= fit(32'h5); r_state <= ST_TX; end
                  8'h06: begin r_resp <= fit(r_count); r_count <= r_count + 32'd1; r_state <= ST_TX; end
                  8'h07: begin r_resp <= fit(32'd259); r_state <= ST_TX; end
                  8'h08: begin r_resp <= fit({16'b0, mem_busy, 7'b0, r_err_cnt}); r_state <= ST_TX; end
                  8'h09: if (!mem_busy) begin r_rd_req <= 1'b1; r_state <= ST_MEM_WAIT; end
                  default: begin r_resp <= '0; r_state <= ST_TX; end
               endcase
            end
            ST_MEM_WAIT: begin
               if (mem_rd_rdy) begin
                  r_resp     <= mem_rd_d;
                  r_mem_addr <= r_mem_addr + ADDR_W'(1);
                  r_state    <= ST_TX;
               end
            end
            ST_TX: begin
               if (ready && !r_in_flight) begin
                  r_tx_strb   <= 1'b1;
                  r_txdata    <= r_resp[DW-1 -: 8];
                  r_resp      <= r_resp << 8;
                  r_in_flight <= 1'b1;
                  r_seen_low  <= 1'b0;
                  if (r_tx_cnt == TCNT_LAST) begin
                     r_tx_cnt <= '0;
                     r_state  <= ST_RX;
                  end else begin
                     r_tx_cnt <= r_tx_cnt + 2'd1;
                  end
               end
            end
            default: r_state <= ST_RX;
         endcase
      end
   end

   assign tx_strb    = r_tx_strb;
   assign txdata     = r_txdata;
   assign mem_addr   = r_mem_addr;
   assign mem_wr_d   = r_wr_d;
   assign mem_wr_req = r_wr_req;
   assign mem_rd_req = r_rd_req;
   assign err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge: a frame table plus hand sequences for memory wait, reset and error paths.
// The timeout sequence is included only when SERIAL_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_serial_mem_bridge;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rcv = 1'b0;
   logic [7:0]  rxdata = 8'h00;
   logic        tx_strb;
   logic [7:0]  txdata;
   logic        ready = 1'b1;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_d;
   logic        mem_wr_req;
   logic        mem_rd_req;
   logic [31:0] mem_rd_d = 32'h0;
   logic        mem_rd_rdy = 1'b0;
   logic        mem_busy = 1'b0;
   logic [7:0]  err_cnt;

   int n_vec = 0;
   int n_fail = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   int both_cnt = 0;
   logic [7:0] rx_q[$];

   serial_mem_bridge #(.DATA_BYTES(4), .ADDR_W(32), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .rcv(rcv), .rxdata(rxdata),
      .tx_strb(tx_strb), .txdata(txdata), .ready(ready),
      .mem_addr(mem_addr), .mem_wr_d(mem_wr_d), .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
      .mem_rd_d(mem_rd_d), .mem_rd_rdy(mem_rd_rdy), .mem_busy(mem_busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Transmitter model: capture each strobed byte, go busy for three cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_strb) begin
            rx_q.push_back(txdata);
            $display("tx byte %02h", txdata);
            ready = 1'b0;
            repeat (3) @(negedge clk);
            ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mem_wr_req) wr_pulses++;
         if (mem_rd_req) rd_pulses++;
         if (mem_wr_req && mem_rd_req) both_cnt++;
      end
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] payload;
      int          busy_cyc;
      logic [31:0] exp_tx;
      logic [31:0] exp_addr;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] payload);
      @(negedge clk);
      rcv = 1'b1;
      rxdata = cmd;
      for (int k = 3; k >= 0; k--) begin
         @(negedge clk);
         rxdata = payload[8*k +: 8];
      end
      @(negedge clk);
      rcv = 1'b0;
   endtask

   task automatic send_bytes(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rcv = 1'b1;
         rxdata = 8'hA0 + 8'(k);
      end
      @(negedge clk);
      rcv = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input string name);
      int cyc;
      cyc = 0;
      while (rx_q.size() < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (rx_q.size() < n) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d tx bytes, expected %0d", name, rx_q.size(), n);
      end
   endtask

   task automatic get_resp(input string name, output logic [31:0] v);
      wait_bytes(4, name);
      v = 32'hxxxxxxxx;
      if (rx_q.size() >= 4) v = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
      repeat (10) @(negedge clk);
      check({name, "_nbytes"}, 32'(rx_q.size()), 32'd4);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [31:0] resp;
   int base_wr, base_rd;

   initial begin
      tbl[0] = '{8'h01, 32'h00000010, 0, 32'h00000010, 32'h00000010, 8'd0};
      tbl[1] = '{8'h02, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h00000010, 8'd0};
      tbl[2] = '{8'h03, 32'h00000000, 5, 32'h00000003, 32'h00000010, 8'd0};
      tbl[3] = '{8'h06, 32'h11111111, 0, 32'h00000000, 32'h00000010, 8'd0};
      tbl[4] = '{8'h06, 32'h22222222, 0, 32'h00000001, 32'h00000010, 8'd0};
      tbl[5] = '{8'h07, 32'h00000000, 0, 32'h00000103, 32'h00000010, 8'd0};
      tbl[6] = '{8'h05, 32'h00000000, 2, 32'h00000005, 32'h00000010, 8'd0};
      tbl[7] = '{8'h7F, 32'h00000000, 0, 32'h00000000, 32'h00000010, 8'd1};
      tbl[8] = '{8'h08, 32'h00000000, 0, 32'h00000001, 32'h00000010, 8'd1};
      tbl[9] = '{8'h01, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd1};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_tx_strb", 32'(tx_strb), 32'd0);
      check("rst_txdata", 32'(txdata), 32'd0);
      check("rst_wr_req", 32'(mem_wr_req), 32'd0);
      check("rst_rd_req", 32'(mem_rd_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wr_d", mem_wr_d, 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);

      for (int i = 0; i < 10; i++) begin
         $display("vector %0d: cmd %02h payload %h busy %0d", i, tbl[i].cmd, tbl[i].payload, tbl[i].busy_cyc);
         base_wr = wr_pulses;
         base_rd = rd_pulses;
         rx_q.delete();
         mem_busy = (tbl[i].busy_cyc > 0);
         send_frame(tbl[i].cmd, tbl[i].payload);
         if (tbl[i].busy_cyc > 0) begin
            repeat (tbl[i].busy_cyc) @(negedge clk);
            check($sformatf("v%0d_no_req_busy", i), 32'((wr_pulses - base_wr) + (rd_pulses - base_rd)), 32'd0);
            mem_busy = 1'b0;
         end
         get_resp($sformatf("v%0d_tx", i), resp);
         check($sformatf("v%0d_tx", i), resp, tbl[i].exp_tx);
         check($sformatf("v%0d_addr", i), mem_addr, tbl[i].exp_addr);
         check($sformatf("v%0d_err", i), 32'(err_cnt), 32'(tbl[i].exp_err));
         if (tbl[i].cmd == 8'h03) begin
            check("write_pulses", 32'(wr_pulses - base_wr), 32'd1);
            check("write_data", mem_wr_d, 32'hDEADBEEF);
         end
         if (tbl[i].cmd == 8'h05) check("readreq_pulses", 32'(rd_pulses - base_rd), 32'd1);
      end

      // READ_INC from the top address wraps to zero.
      base_rd = rd_pulses;
      rx_q.delete();
      send_frame(8'h09, 32'h00000000);
      repeat (3) @(negedge clk);
      check("readinc_pulses", 32'(rd_pulses - base_rd), 32'd1);
      check("readinc_waiting", 32'(rx_q.size()), 32'd0);
      mem_rd_d = 32'h12345678;
      mem_rd_rdy = 1'b1;
      @(negedge clk);
      mem_rd_rdy = 1'b0;
      get_resp("readinc_tx", resp);
      check("readinc_tx", resp, 32'h12345678);
      check("readinc_addr_wrap", mem_addr, 32'h00000000);
      rx_q.delete();
      send_frame(8'h04, 32'h0);
      get_resp("read_hold", resp);
      check("read_hold", resp, 32'h12345678);

      // Reset in the middle of a response abandons the rest.
      rx_q.delete();
      send_frame(8'h01, 32'h12340000);
      get_resp("addr2", resp);
      check("addr2", mem_addr, 32'h12340000);
      rx_q.delete();
      send_frame(8'h07, 32'h0);
      wait_bytes(1, "pre_reset");
      do_reset();
      repeat (30) @(negedge clk);
      check("reset_mid_tx_bytes", 32'(rx_q.size()), 32'd1);
      check("reset_mid_tx_addr", mem_addr, 32'd0);
      check("reset_mid_tx_err", 32'(err_cnt), 32'd0);
      check("reset_mid_tx_wr_d", mem_wr_d, 32'd0);
      mem_rd_d = 32'hCAFEF00D;
      mem_rd_rdy = 1'b1;
      @(negedge clk);
      mem_rd_rdy = 1'b0;
      repeat (10) @(negedge clk);
      check("rdy_after_reset_no_tx", 32'(rx_q.size()), 32'd1);
      check("rdy_after_reset_addr", mem_addr, 32'd0);
      rx_q.delete();
      send_frame(8'h04, 32'h0);
      get_resp("hold_after_reset", resp);
      check("hold_after_reset", resp, 32'hCAFEF00D);
      rx_q.delete();
      send_frame(8'h06, 32'h0);
      get_resp("count_after_reset", resp);
      check("count_after_reset", resp, 32'd0);

      // Unknown command, then bytes arriving during the response.
      do_reset();
      rx_q.delete();
      send_frame(8'h7F, 32'h0);
      wait_bytes(1, "unknown_first");
      check("unknown_err", 32'(err_cnt), 32'd1);
      send_bytes(3);
      get_resp("unknown_tx", resp);
      check("unknown_tx", resp, 32'h00000000);
      check("extra_bytes_err", 32'(err_cnt), 32'd4);

`ifdef SERIAL_MEM_BRIDGE_TIMEOUT_EN
      do_reset();
      rx_q.delete();
      @(negedge clk);
      rcv = 1'b1;
      rxdata = 8'h07;
      @(negedge clk);
      rxdata = 8'h55;
      @(negedge clk);
      rcv = 1'b0;
      repeat (105) @(negedge clk);
      send_frame(8'h07, 32'h0);
      get_resp("timeout_tx", resp);
      check("timeout_tx", resp, 32'h00000103);
      check("timeout_err", 32'(err_cnt), 32'd1);
`endif

      check("no_wr_rd_overlap", 32'(both_cnt), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
